// File: rtl/slot_game_ctrl.sv
// Slot machine game controller: coin credit, reel start/stop sequencing and
// payout scoring. Sits between debounced front-panel buttons and the reel
// counters; every output is registered for the display muxes.
//
// Input event semantics: COIN_IN, START and STOP_BTN are levels. An event is a
// rising edge seen against the registered previous level. The previous levels
// reset to ones, so a button held through reset never produces an event.
// There is no back-pressure: every event is consumed in the cycle it appears,
// or dropped if the current state ignores it.
module slot_game_ctrl #(
    parameter int NUM_REELS  = 3,
    parameter int SYM_W      = 4,
    parameter int CREDIT_W   = 7,
    parameter int CREDIT_MAX = 99,
    parameter int BET        = 1,
    parameter int PAY_PAIR   = 5,
    parameter int PAY_ALL    = 10
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       COIN_IN,
    input  logic                       START,
    input  logic [NUM_REELS-1:0]       STOP_BTN,
    input  logic [NUM_REELS*SYM_W-1:0] REEL_VAL,
    output logic [NUM_REELS-1:0]       REEL_RUN,
    output logic [CREDIT_W-1:0]        CREDIT,
    output logic [2:0]                 STATE,
    output logic [3:0]                 MATCH,
    output logic [CREDIT_W-1:0]        PAYOUT,
    output logic                       WIN
);

    // Two guard bits so credit + coin + payout never wraps before saturation.
    localparam int SUM_W = CREDIT_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_SPIN   = 3'd2,
        ST_EVAL   = 3'd3,
        ST_PAY    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [NUM_REELS-1:0]  run_q, run_d;
    logic [3:0]            match_q, match_d;
    logic [CREDIT_W-1:0]   payout_q, payout_d;
    logic                  win_q, win_d;

    logic                  coin_prev, start_prev;
    logic [NUM_REELS-1:0]  stop_prev;
    logic                  coin_edge, start_edge;
    logic [NUM_REELS-1:0]  stop_edge;

    logic                  start_ok;
    logic [CREDIT_W-1:0]   pay_add;
    logic [SUM_W-1:0]      bet_sub;
    logic [SUM_W-1:0]      credit_sum;
    logic [CREDIT_W-1:0]   credit_sat;

    logic [3:0]            eval_cnt;
    logic [3:0]            eval_match;
    logic [CREDIT_W-1:0]   eval_payout;

    assign coin_edge  = COIN_IN & ~coin_prev;
    assign start_edge = START & ~start_prev;
    assign stop_edge  = STOP_BTN & ~stop_prev;

    // Previous button levels for rising-edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            coin_prev  <= 1'b1;
            start_prev <= 1'b1;
            stop_prev  <= '1;
        end else begin
            coin_prev  <= COIN_IN;
            start_prev <= START;
            stop_prev  <= STOP_BTN;
        end
    end

    // Credit update: every delta of this cycle summed once, then saturated.
    always_comb begin
        start_ok   = (state_q == ST_CREDIT) && start_edge && (credit_q >= CREDIT_W'(BET));
        pay_add    = (state_q == ST_PAY) ? payout_q : '0;
        bet_sub    = start_ok ? SUM_W'(BET) : '0;
        credit_sum = {2'b00, credit_q} + {{(SUM_W-1){1'b0}}, coin_edge}
                     + {2'b00, pay_add} - bet_sub;
        credit_sat = (credit_sum > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX)
                                                       : credit_sum[CREDIT_W-1:0];
    end

    // Largest equal-symbol group among the stopped reels.
    always_comb begin
        eval_match = '0;
        eval_cnt   = '0;
        for (int i = 0; i < NUM_REELS; i++) begin
            eval_cnt = '0;
            for (int j = 0; j < NUM_REELS; j++) begin
                if (REEL_VAL[i*SYM_W +: SYM_W] == REEL_VAL[j*SYM_W +: SYM_W])
                    eval_cnt = eval_cnt + 4'd1;
            end
            if (eval_cnt > eval_match)
                eval_match = eval_cnt;
        end
    end

    // Payout rule; all-equal wins over pair, so with two reels a pair pays PAY_ALL.
    always_comb begin
        eval_payout = '0;
        if (eval_match == 4'(NUM_REELS))
            eval_payout = CREDIT_W'(PAY_ALL);
        else if (eval_match >= 4'd2)
            eval_payout = CREDIT_W'(PAY_PAIR);
    end

    // Game sequencing: next state and next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_sat;
        run_d    = run_q;
        match_d  = match_q;
        payout_d = payout_q;
        win_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_edge)
                    state_d = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (start_ok) begin
                    run_d   = '1;
                    state_d = ST_SPIN;
                end
            end
            ST_SPIN: begin
                run_d = run_q & ~stop_edge;
                if (run_d == '0)
                    state_d = ST_EVAL;
            end
            ST_EVAL: begin
                match_d  = eval_match;
                payout_d = eval_payout;
                state_d  = ST_PAY;
            end
            ST_PAY: begin
                win_d   = (payout_q != '0);
                state_d = (credit_sat != '0) ? ST_CREDIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any game in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            run_q    <= '0;
            match_q  <= '0;
            payout_q <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            run_q    <= run_d;
            match_q  <= match_d;
            payout_q <= payout_d;
            win_q    <= win_d;
        end
    end

    assign STATE    = state_q;
    assign CREDIT   = credit_q;
    assign REEL_RUN = run_q;
    assign MATCH    = match_q;
    assign PAYOUT   = payout_q;
    assign WIN      = win_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: a default 3-reel instance (a) and a 5-reel, BET=2
// instance (b). Expected output vectors are queued in the order the outputs
// must change; the monitor pops one per observed change.
module tb_slot_game_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, coin_a, start_a;
    logic [2:0]  stop_a;
    logic [11:0] val_a;
    logic [2:0]  run_a;
    logic [6:0]  credit_a, payout_a;
    logic [2:0]  state_a;
    logic [3:0]  match_a;
    logic        win_a;

    logic        rst_b, coin_b, start_b;
    logic [4:0]  stop_b;
    logic [19:0] val_b;
    logic [4:0]  run_b;
    logic [6:0]  credit_b, payout_b;
    logic [2:0]  state_b;
    logic [3:0]  match_b;
    logic        win_b;

    slot_game_ctrl dut_a (
        .CLK(clk), .RST(rst_a), .COIN_IN(coin_a), .START(start_a),
        .STOP_BTN(stop_a), .REEL_VAL(val_a), .REEL_RUN(run_a),
        .CREDIT(credit_a), .STATE(state_a), .MATCH(match_a),
        .PAYOUT(payout_a), .WIN(win_a)
    );

    slot_game_ctrl #(.NUM_REELS(5), .BET(2)) dut_b (
        .CLK(clk), .RST(rst_b), .COIN_IN(coin_b), .START(start_b),
        .STOP_BTN(stop_b), .REEL_VAL(val_b), .REEL_RUN(run_b),
        .CREDIT(credit_b), .STATE(state_b), .MATCH(match_b),
        .PAYOUT(payout_b), .WIN(win_b)
    );

    // ---------------- scoreboard ----------------
    // Vector layout (a): {7'0, state, credit, run[2:0], match, payout, win}
    // Vector layout (b): {5'0, state, credit, run[4:0], match, payout, win}
    logic [31:0] exp_qa[$];
    logic [31:0] exp_qb[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cycles = 0;
    bit mon_on = 1'b0;
    bit done   = 1'b0;
    logic [31:0] last_a, last_b, cur_a, cur_b, e;

    task automatic exp_a(input [2:0] s, input [6:0] c, input [2:0] r,
                         input [3:0] m, input [6:0] p, input w);
        exp_qa.push_back({7'd0, s, c, r, m, p, w});
    endtask

    task automatic exp_b(input [2:0] s, input [6:0] c, input [4:0] r,
                         input [3:0] m, input [6:0] p, input w);
        exp_qb.push_back({5'd0, s, c, r, m, p, w});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            cycles++;
            cur_a = {7'd0, state_a, credit_a, run_a, match_a, payout_a, win_a};
            cur_b = {5'd0, state_b, credit_b, run_b, match_b, payout_b, win_b};
            if (cur_a != last_a) begin
                n_cmp++;
                if (exp_qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_a unexpected change @%0t: got %h want no change", $time, cur_a);
                end else begin
                    e = exp_qa.pop_front();
                    if (e != cur_a) begin
                        n_fail++;
                        $display("FAIL out_a @%0t: got st=%0d cr=%0d run=%b m=%0d p=%0d w=%0d want st=%0d cr=%0d run=%b m=%0d p=%0d w=%0d",
                                 $time, cur_a[24:22], cur_a[21:15], cur_a[14:12], cur_a[11:8], cur_a[7:1], cur_a[0],
                                 e[24:22], e[21:15], e[14:12], e[11:8], e[7:1], e[0]);
                    end
                end
                last_a = cur_a;
            end
            if (cur_b != last_b) begin
                n_cmp++;
                if (exp_qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_b unexpected change @%0t: got %h want no change", $time, cur_b);
                end else begin
                    e = exp_qb.pop_front();
                    if (e != cur_b) begin
                        n_fail++;
                        $display("FAIL out_b @%0t: got st=%0d cr=%0d run=%b m=%0d p=%0d w=%0d want st=%0d cr=%0d run=%b m=%0d p=%0d w=%0d",
                                 $time, cur_b[26:24], cur_b[23:17], cur_b[16:12], cur_b[11:8], cur_b[7:1], cur_b[0],
                                 e[26:24], e[23:17], e[16:12], e[11:8], e[7:1], e[0]);
                    end
                end
                last_b = cur_b;
            end
            if (done || cycles > 5000) begin
                if (!done) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL timeout: got %0d cycles want stimulus done", cycles);
                end
                n_cmp++;
                if (exp_qa.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_a: got %0d outstanding want 0", exp_qa.size());
                end
                n_cmp++;
                if (exp_qb.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_b: got %0d outstanding want 0", exp_qb.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin_a_pulse();
        coin_a = 1'b1; tick(1); coin_a = 1'b0; tick(1);
    endtask

    task automatic start_a_pulse();
        start_a = 1'b1; tick(1); start_a = 1'b0; tick(1);
    endtask

    task automatic stop_a_pulse(input [2:0] m);
        stop_a = m; tick(1); stop_a = 3'b000; tick(1);
    endtask

    task automatic coin_b_pulse();
        coin_b = 1'b1; tick(1); coin_b = 1'b0; tick(1);
    endtask

    task automatic start_b_pulse();
        start_b = 1'b1; tick(1); start_b = 1'b0; tick(1);
    endtask

    task automatic stop_b_pulse(input [4:0] m);
        stop_b = m; tick(1); stop_b = 5'b00000; tick(1);
    endtask

    // One game on instance a with all reels stopped together. Arguments are
    // the hand-computed outputs: prior match/payout, credit after the bet,
    // new match/payout, final credit/state and whether WIN pulses.
    task automatic game_a(input [11:0] vals, input [3:0] pm, input [6:0] pp,
                          input [6:0] c_run, input [3:0] m, input [6:0] p,
                          input bit coin_pay, input [6:0] c_end,
                          input [2:0] s_end, input bit w);
        val_a = vals;
        exp_a(3'd2, c_run, 3'b111, pm, pp, 1'b0);
        start_a_pulse();
        exp_a(3'd3, c_run, 3'b000, pm, pp, 1'b0);
        exp_a(3'd4, c_run, 3'b000, m, p, 1'b0);
        if (w) begin
            exp_a(s_end, c_end, 3'b000, m, p, 1'b1);
            exp_a(s_end, c_end, 3'b000, m, p, 1'b0);
        end else begin
            exp_a(s_end, c_end, 3'b000, m, p, 1'b0);
        end
        stop_a = 3'b111; tick(1);      // edge t: -> EVAL
        stop_a = 3'b000; tick(1);      // edge t+1: -> PAY
        if (coin_pay) coin_a = 1'b1;   // edge t+2: coin lands in PAY
        tick(1);
        coin_a = 1'b0;
        tick(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        coin_a = 1'b0; start_a = 1'b1; stop_a = '0; val_a = '0;
        coin_b = 1'b0; start_b = 1'b0; stop_b = '0; val_b = '0;
        last_a = '1; last_b = '1;
        exp_a(3'd0, 7'd0, 3'b000, 4'd0, 7'd0, 1'b0);
        exp_b(3'd0, 7'd0, 5'b00000, 4'd0, 7'd0, 1'b0);
        mon_on = 1'b1;
        tick(3);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(3);

        // START held through reset release, then a coin: no game starts.
        exp_a(3'd1, 7'd1, 3'b000, 4'd0, 7'd0, 1'b0);
        coin_a_pulse();
        tick(2);
        start_a = 1'b0;
        tick(1);

        // Losing game 1,2,3 with credit 0 after the bet -> IDLE, no WIN.
        val_a = {4'd3, 4'd2, 4'd1};
        exp_a(3'd2, 7'd0, 3'b111, 4'd0, 7'd0, 1'b0);
        start_a_pulse();
        exp_a(3'd2, 7'd0, 3'b110, 4'd0, 7'd0, 1'b0);
        stop_a_pulse(3'b001);
        exp_a(3'd2, 7'd0, 3'b100, 4'd0, 7'd0, 1'b0);
        stop_a_pulse(3'b010);
        exp_a(3'd3, 7'd0, 3'b000, 4'd0, 7'd0, 1'b0);
        exp_a(3'd4, 7'd0, 3'b000, 4'd1, 7'd0, 1'b0);
        exp_a(3'd0, 7'd0, 3'b000, 4'd1, 7'd0, 1'b0);
        stop_a_pulse(3'b100);
        tick(3);

        // START and STOP in IDLE are ignored.
        start_a_pulse();
        stop_a_pulse(3'b111);
        tick(2);

        // Coin, start, stop order 2,0,1 on 7,7,7 (START in SPIN ignored).
        exp_a(3'd1, 7'd1, 3'b000, 4'd1, 7'd0, 1'b0);
        coin_a_pulse();
        exp_a(3'd2, 7'd0, 3'b111, 4'd1, 7'd0, 1'b0);
        start_a_pulse();
        val_a = 12'h777;
        exp_a(3'd2, 7'd0, 3'b011, 4'd1, 7'd0, 1'b0);
        stop_a_pulse(3'b100);
        start_a_pulse();
        exp_a(3'd2, 7'd0, 3'b010, 4'd1, 7'd0, 1'b0);
        stop_a_pulse(3'b001);
        exp_a(3'd3, 7'd0, 3'b000, 4'd1, 7'd0, 1'b0);
        exp_a(3'd4, 7'd0, 3'b000, 4'd3, 7'd10, 1'b0);
        exp_a(3'd1, 7'd10, 3'b000, 4'd3, 7'd10, 1'b1);
        exp_a(3'd1, 7'd10, 3'b000, 4'd3, 7'd10, 1'b0);
        stop_a_pulse(3'b010);
        tick(3);

        // 3,3,5 stopped together, coin during PAY: 9 + 5 + 1 = 15.
        game_a(12'h533, 4'd3, 7'd10, 7'd9, 4'd2, 7'd5, 1'b1, 7'd15, 3'd1, 1'b1);

        // Coins up to 98.
        for (int c = 16; c <= 98; c++) begin
            exp_a(3'd1, 7'(c), 3'b000, 4'd2, 7'd5, 1'b0);
            coin_a_pulse();
        end

        // Coin and START in the same cycle at 98: 98 + 1 - 1 = 98.
        exp_a(3'd2, 7'd98, 3'b111, 4'd2, 7'd5, 1'b0);
        coin_a = 1'b1; start_a = 1'b1; tick(1);
        coin_a = 1'b0; start_a = 1'b0; tick(1);

        // Five coins during SPIN: 99 once, then saturated (no further change).
        exp_a(3'd2, 7'd99, 3'b111, 4'd2, 7'd5, 1'b0);
        repeat (5) coin_a_pulse();

        // Win of 10 on top of 99 stays at 99 but still pulses WIN.
        val_a = 12'h777;
        exp_a(3'd3, 7'd99, 3'b000, 4'd2, 7'd5, 1'b0);
        exp_a(3'd4, 7'd99, 3'b000, 4'd3, 7'd10, 1'b0);
        exp_a(3'd1, 7'd99, 3'b000, 4'd3, 7'd10, 1'b1);
        exp_a(3'd1, 7'd99, 3'b000, 4'd3, 7'd10, 1'b0);
        stop_a_pulse(3'b111);
        tick(3);

        // Three losses bring credit from 99 to 96.
        game_a(12'h321, 4'd3, 7'd10, 7'd98, 4'd1, 7'd0, 1'b0, 7'd98, 3'd1, 1'b0);
        game_a(12'h321, 4'd1, 7'd0,  7'd97, 4'd1, 7'd0, 1'b0, 7'd97, 3'd1, 1'b0);
        game_a(12'h321, 4'd1, 7'd0,  7'd96, 4'd1, 7'd0, 1'b0, 7'd96, 3'd1, 1'b0);

        // Credit 95 in PAY with PAYOUT 10 plus a coin: 106 saturates at 99.
        game_a(12'h777, 4'd1, 7'd0, 7'd95, 4'd3, 7'd10, 1'b1, 7'd99, 3'd1, 1'b1);

        // ---- instance b: 5 reels, BET = 2 ----
        exp_b(3'd1, 7'd1, 5'b00000, 4'd0, 7'd0, 1'b0);
        coin_b_pulse();
        start_b_pulse();                         // 1 < BET: ignored
        tick(2);
        exp_b(3'd1, 7'd2, 5'b00000, 4'd0, 7'd0, 1'b0);
        coin_b_pulse();
        exp_b(3'd2, 7'd0, 5'b11111, 4'd0, 7'd0, 1'b0);
        start_b_pulse();
        exp_b(3'd2, 7'd0, 5'b10111, 4'd0, 7'd0, 1'b0);
        stop_b_pulse(5'b01000);
        stop_b_pulse(5'b01000);                  // already stopped: ignored
        exp_b(3'd2, 7'd0, 5'b10110, 4'd0, 7'd0, 1'b0);
        stop_b_pulse(5'b00001);
        // reels 0..4 = 4,9,4,4,9: group of three -> pair rule pays 5.
        val_b = {4'd9, 4'd4, 4'd4, 4'd9, 4'd4};
        exp_b(3'd3, 7'd0, 5'b00000, 4'd0, 7'd0, 1'b0);
        exp_b(3'd4, 7'd0, 5'b00000, 4'd3, 7'd5, 1'b0);
        exp_b(3'd1, 7'd5, 5'b00000, 4'd3, 7'd5, 1'b1);
        exp_b(3'd1, 7'd5, 5'b00000, 4'd3, 7'd5, 1'b0);
        stop_b_pulse(5'b10110);
        tick(3);
        exp_b(3'd2, 7'd3, 5'b11111, 4'd3, 7'd5, 1'b0);
        start_b_pulse();
        exp_b(3'd2, 7'd3, 5'b11101, 4'd3, 7'd5, 1'b0);
        stop_b_pulse(5'b00010);

        // Reset mid-SPIN: everything back to reset values, no later activity.
        exp_b(3'd0, 7'd0, 5'b00000, 4'd0, 7'd0, 1'b0);
        #2 rst_b = 1'b1;
        tick(2);
        stop_b_pulse(5'b11111);
        rst_b = 1'b0;
        tick(1);
        stop_b_pulse(5'b11101);
        start_b_pulse();
        tick(5);
        done = 1'b1;
    end

endmodule
